// File: rtl/lcd1602_seq.sv
// HD44780/LCD1602 bus sequencer: Z80 writes are queued in a small FIFO and
// replayed with proper E timing, each followed by busy-flag polling.
module lcd1602_seq #(
    parameter int T_AS      = 2,
    parameter int T_PW      = 11,
    parameter int T_H       = 2,
    parameter int MAX_POLLS = 255,
    parameter int DEPTH     = 4
) (
    input  logic       in_clock,
    input  logic       rst,
    input  logic       wr_stb,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    input  logic       clr_err,
    output logic       fifo_full,
    output logic       idle,
    output logic       ovf_err,
    output logic       tmo_err,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_d_out,
    output logic       lcd_d_oe,
    input  logic [7:0] lcd_d_in
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int PW    = $clog2(MAX_POLLS + 1);
    localparam int T_MAX = (T_PW > T_AS) ? ((T_PW > T_H) ? T_PW : T_H)
                                         : ((T_AS > T_H) ? T_AS : T_H);
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] LD_AS = TW'(T_AS - 1);
    localparam logic [TW-1:0] LD_PW = TW'(T_PW - 1);
    localparam logic [TW-1:0] LD_H  = TW'(T_H - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_W_SU = 3'd1;
    localparam logic [2:0] S_W_E  = 3'd2;
    localparam logic [2:0] S_W_H  = 3'd3;
    localparam logic [2:0] S_B_SU = 3'd4;
    localparam logic [2:0] S_B_E  = 3'd5;
    localparam logic [2:0] S_B_H  = 3'd6;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovf_evt;

    logic [2:0]    state;
    logic [TW-1:0] phase;
    logic [PW-1:0] polls;
    logic          busy_q;

    // Only the busy flag is used; the address counter bits are ignored.
    logic unused_bits;
    assign unused_bits = ^lcd_d_in[6:0];

    assign full    = (count == CW'(DEPTH));
    assign pop     = (state == S_IDLE) && (count != '0);
    // A push into a full FIFO still lands when the FSM pops in the same cycle.
    assign push    = wr_stb && (!full || pop);
    assign ovf_evt = wr_stb && full && !pop;

    assign fifo_full = full;
    assign idle      = (state == S_IDLE) && (count == '0);

    always_ff @(posedge in_clock) begin
        if (push) begin
            mem[wr_ptr] <= {wr_rs, wr_data};
        end
    end

    always_ff @(posedge in_clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge in_clock) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= '0;
            polls     <= '0;
            busy_q    <= 1'b0;
            ovf_err   <= 1'b0;
            tmo_err   <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_d_out <= '0;
            lcd_d_oe  <= 1'b0;
        end else begin
            // Clear first so a coincident error event below overrides it.
            if (clr_err) begin
                ovf_err <= 1'b0;
                tmo_err <= 1'b0;
            end
            if (ovf_evt) begin
                ovf_err <= 1'b1;
            end
            if (phase != '0) begin
                phase <= phase - TW'(1);
            end

            case (state)
                S_IDLE: begin
                    lcd_e    <= 1'b0;
                    lcd_d_oe <= 1'b0;
                    if (pop) begin
                        lcd_rs    <= mem[rd_ptr][8];
                        lcd_d_out <= mem[rd_ptr][7:0];
                        lcd_rw    <= 1'b0;
                        lcd_d_oe  <= 1'b1;
                        phase     <= LD_AS;
                        state     <= S_W_SU;
                    end
                end
                S_W_SU: begin
                    if (phase == '0) begin
                        lcd_e <= 1'b1;
                        phase <= LD_PW;
                        state <= S_W_E;
                    end
                end
                S_W_E: begin
                    if (phase == '0) begin
                        lcd_e <= 1'b0;
                        phase <= LD_H;
                        state <= S_W_H;
                    end
                end
                S_W_H: begin
                    // Bus turnaround: stop driving on the same edge RW goes high.
                    if (phase == '0) begin
                        lcd_rs   <= 1'b0;
                        lcd_rw   <= 1'b1;
                        lcd_d_oe <= 1'b0;
                        polls    <= '0;
                        phase    <= LD_AS;
                        state    <= S_B_SU;
                    end
                end
                S_B_SU: begin
                    if (phase == '0) begin
                        lcd_e <= 1'b1;
                        phase <= LD_PW;
                        state <= S_B_E;
                    end
                end
                S_B_E: begin
                    if (phase == '0) begin
                        busy_q <= lcd_d_in[7];
                        lcd_e  <= 1'b0;
                        phase  <= LD_H;
                        state  <= S_B_H;
                    end
                end
                S_B_H: begin
                    if (phase == '0) begin
                        if (!busy_q) begin
                            lcd_rw <= 1'b0;
                            state  <= S_IDLE;
                        end else if (polls < PW'(MAX_POLLS)) begin
                            polls <= polls + PW'(1);
                            phase <= LD_AS;
                            state <= S_B_SU;
                        end else begin
                            tmo_err <= 1'b1;
                            lcd_rw  <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    lcd_e    <= 1'b0;
                    lcd_rw   <= 1'b0;
                    lcd_d_oe <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd1602_seq.sv
// Directed bench for lcd1602_seq: LCD timing, busy polling, timeout,
// FIFO overflow/ordering and mid-transaction reset.
module tb_lcd1602_seq;
    logic       in_clock = 1'b0;
    logic       rst;
    logic       wr_stb;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       clr_err;
    logic       fifo_full;
    logic       idle;
    logic       ovf_err;
    logic       tmo_err;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_d_out;
    logic       lcd_d_oe;
    logic [7:0] lcd_d_in;

    int n_checks = 0;
    int n_fail   = 0;
    int oe_bad   = 0;
    logic [8:0] wq[$];

    logic       e_tr  [0:40];
    logic       rs_tr [0:40];
    logic       rw_tr [0:40];
    logic       oe_tr [0:40];
    logic       id_tr [0:40];
    logic [7:0] d_tr  [0:40];

    always #5 in_clock = ~in_clock;

    lcd1602_seq dut (
        .in_clock  (in_clock),
        .rst       (rst),
        .wr_stb    (wr_stb),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .clr_err   (clr_err),
        .fifo_full (fifo_full),
        .idle      (idle),
        .ovf_err   (ovf_err),
        .tmo_err   (tmo_err),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_d_out (lcd_d_out),
        .lcd_d_oe  (lcd_d_oe),
        .lcd_d_in  (lcd_d_in)
    );

    task automatic tick;
        @(posedge in_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // LCD model: the k-th busy poll of an entry reports busy while k <= nb.
    task automatic run_to_idle(input int max_cycles, input int nb_first, input int nb_rest,
                               output int bf, output int wr, output bit to);
        int   entry;
        int   polls_seen;
        logic prev_e;
        entry = 0; polls_seen = 0; prev_e = lcd_e;
        bf = 0; wr = 0; to = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            tick;
            if (lcd_rw && lcd_d_oe) oe_bad++;
            if (lcd_e && !prev_e) begin
                if (!lcd_rw) begin
                    wq.push_back({lcd_rs, lcd_d_out});
                    wr++;
                    entry++;
                    polls_seen = 0;
                end else begin
                    bf++;
                    polls_seen++;
                    lcd_d_in = (((entry == 1) ? nb_first : nb_rest) >= polls_seen) ? 8'h80 : 8'h00;
                end
            end
            prev_e = lcd_e;
            if (idle && !lcd_e) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] d);
        wr_stb = 1'b1; wr_rs = rs; wr_data = d;
        tick;
        wr_stb = 1'b0;
    endtask

    initial begin
        int bf, wr, cnt, bad;
        bit to, ok;

        rst = 1'b1; wr_stb = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;
        clr_err = 1'b0; lcd_d_in = 8'h00;
        tick; tick; tick;
        check("rst_e", lcd_e, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_oe", lcd_d_oe, 0);
        check("rst_dout", lcd_d_out, 0);
        check("rst_full", fifo_full, 0);
        check("rst_idle", idle, 1);
        check("rst_ovf", ovf_err, 0);
        check("rst_tmo", tmo_err, 0);
        rst = 1'b0;
        tick;

        // Single command 0x38: cycle 0 is the push cycle.
        wr_stb = 1'b1; wr_rs = 1'b0; wr_data = 8'h38;
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (c == 1) wr_stb = 1'b0;
            e_tr[c] = lcd_e; rs_tr[c] = lcd_rs; rw_tr[c] = lcd_rw;
            oe_tr[c] = lcd_d_oe; id_tr[c] = idle; d_tr[c] = lcd_d_out;
        end
        check("c1_idle", id_tr[1], 0);
        check("c1_oe", oe_tr[1], 0);
        check("e_before_rise", e_tr[3], 0);
        check("e_rise_c4", e_tr[4], 1);
        cnt = 0;
        for (int c = 1; c <= 16; c++) cnt += int'(e_tr[c]);
        check("e_width", cnt, 11);
        check("e_fall_c15", e_tr[15], 0);
        bad = 0;
        for (int c = 2; c <= 16; c++)
            if ({rs_tr[c], rw_tr[c], oe_tr[c], d_tr[c]} !== {3'b001, 8'h38}) bad++;
        check("wr_bus_stable", bad, 0);
        check("bf_rw_oe_c17", {rw_tr[17], oe_tr[17], rs_tr[17]}, 3'b100);
        check("bf_e_rise", {e_tr[18], e_tr[19]}, 2'b01);
        cnt = 0;
        for (int c = 17; c <= 31; c++) cnt += int'(e_tr[c]);
        check("bf_e_width", cnt, 11);
        check("idle_c31", id_tr[31], 0);
        check("idle_c32", {id_tr[32], rw_tr[32]}, 2'b10);

        // Busy for three polls, then ready.
        push(1'b0, 8'h01);
        run_to_idle(500, 3, 0, bf, wr, to);
        check("busy3_done", to, 0);
        check("busy3_pulses", bf, 4);
        check("busy3_writes", wr, 1);
        check("busy3_tmo", tmo_err, 0);
        check("oe_rw_excl_a", oe_bad, 0);

        // Stuck busy, with a second entry queued behind it.
        wq.delete();
        push(1'b0, 8'h01);
        push(1'b1, 8'h41);
        run_to_idle(6000, 100000, 0, bf, wr, to);
        check("stuck_done", to, 0);
        check("stuck_pulses", bf, 257);
        check("stuck_writes", wr, 2);
        check("stuck_tmo", tmo_err, 1);
        check("stuck_second", (wq.size() == 2) ? wq[1] : 9'h000, {1'b1, 8'h41});
        clr_err = 1'b1; tick; clr_err = 1'b0;
        check("tmo_clr", tmo_err, 0);

        // Overflow: five pushes while the FSM is busy with 0x80.
        push(1'b0, 8'h80);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (lcd_d_oe) begin ok = 1'b1; break; end
            tick;
        end
        check("wait_oe", ok, 1);
        for (int i = 0; i < 5; i++) begin
            wr_stb = 1'b1; wr_rs = i[0]; wr_data = 8'hA0 + 8'(i);
            tick;
            if (i == 3) check("full_after4", {fifo_full, ovf_err}, 2'b10);
        end
        wr_stb = 1'b0;
        check("ovf_after5", {fifo_full, ovf_err}, 2'b11);
        clr_err = 1'b1; tick; clr_err = 1'b0;
        check("ovf_clr", ovf_err, 0);

        // Push into the full FIFO on the cycle the FSM pops.
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick;
            if (lcd_rw) begin ok = 1'b1; break; end
        end
        check("wait_rw_hi", ok, 1);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick;
            if (!lcd_rw) begin ok = 1'b1; break; end
        end
        check("wait_rw_lo", ok, 1);
        push(1'b1, 8'hA5);
        check("pop_push_full", {fifo_full, ovf_err}, 2'b10);
        wq.delete();
        run_to_idle(1000, 0, 0, bf, wr, to);
        check("order_done", to, 0);
        check("order_writes", wr, 5);
        check("order_0", (wq.size() > 0) ? wq[0] : 9'h1FF, {1'b0, 8'hA0});
        check("order_1", (wq.size() > 1) ? wq[1] : 9'h1FF, {1'b1, 8'hA1});
        check("order_2", (wq.size() > 2) ? wq[2] : 9'h1FF, {1'b0, 8'hA2});
        check("order_3", (wq.size() > 3) ? wq[3] : 9'h1FF, {1'b1, 8'hA3});
        check("order_4", (wq.size() > 4) ? wq[4] : 9'h1FF, {1'b1, 8'hA5});
        check("oe_rw_excl_b", oe_bad, 0);

        // Reset while E is high on a write, with entries queued.
        push(1'b0, 8'h38);
        push(1'b1, 8'h55);
        push(1'b1, 8'h66);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (lcd_e) begin ok = 1'b1; break; end
            tick;
        end
        check("wait_we", {ok, lcd_rw}, 2'b10);
        rst = 1'b1; tick; rst = 1'b0;
        check("midrst_e_oe", {lcd_e, lcd_d_oe}, 2'b00);
        check("midrst_idle", idle, 1);
        check("midrst_full", fifo_full, 0);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            tick;
            if (lcd_e || lcd_d_oe) cnt++;
        end
        check("midrst_no_replay", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
